scan_window_ctrl: RTL and testbench
===================================

# scan_window_ctrl

Sequences a rectangular pixel scan over a framebuffer window: on a start request it latches origin and size, then emits one framebuffer address plus (x, y) coordinate per accepted beat, row-major, under valid/ready backpressure. It drives the read or write port of the framebuffer memory (pixel pipeline, sprite blitter, camera writer) and replaces ad-hoc pairs of free-running column/row counters with one clipped, handshaked sequencer.

## Interface
Parameters:
- HRES, 320, framebuffer width in pixels (row pitch)
- VRES, 240, framebuffer height in pixels
- COORD_WIDTH, 9, width of x/y coordinates and window sizes
- ADDR_WIDTH, 17, width of linear address; must hold HRES*VRES-1

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-high
- start_in  input  1  request a scan; sampled only in IDLE
- x0_in, y0_in  input  COORD_WIDTH  window origin
- w_in, h_in  input  COORD_WIDTH  window width/height in pixels
- ready_in  input  1  consumer accepts current beat
- valid_out  output  1  addr/x/y hold a valid beat
- addr_out  output  ADDR_WIDTH  y*HRES + x
- x_out, y_out  output  COORD_WIDTH  coordinate of current beat
- last_out  output  1  current beat is final pixel of window
- busy_out  output  1  scan in progress (RUN state)
- done_out  output  1  single-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start_in high -> latch inputs, apply clipping, go RUN (or DONE if clipped window empty). Starts in RUN/DONE ignored.
- Clipping: effective w = min(w_in, HRES-x0_in), h = min(h_in, VRES-y0_in); x0_in>=HRES, y0_in>=VRES, w_in==0 or h_in==0 -> empty window.
- RUN: beat transfers when valid_out && ready_in. Column advances; at column end x returns to x0 and row advances; after final beat go DONE.
- Address computed incrementally, no multiplier: row base register starts at y0*HRES (computed once at latch via shift-add iteration or constant-multiply; one-cycle latch latency permitted), adds HRES per row; addr = row base + x.
- last_out high exactly when x = x0+w-1 and y = y0+h-1 with valid_out.
- DONE: done_out high one cycle, return to IDLE.
- Reset mid-scan: immediate return to IDLE, all outputs to reset values; no done pulse.

## Timing
- Reset values: valid_out=0, last_out=0, busy_out=0, done_out=0, addr_out=0, x_out=0, y_out=0, state IDLE.
- All outputs registered.
- Start sampled at edge N -> busy_out and valid_out high from cycle N+1 (first beat x0,y0).
- While valid_out && !ready_in: addr/x/y/last held stable.
- One beat per cycle with ready_in held high; window of w*h pixels takes w*h cycles in RUN.
- Final handshake at edge M -> valid_out, busy_out low cycle M+1; done_out high cycle M+1 only.
- Empty window: start at N -> done_out high cycle N+1, valid_out never asserted.
- Earliest next start accepted: cycle after done_out.

## Configuration
- SCAN_ABORT_EN defined: extra input abort_in (1 bit). abort_in high in RUN -> next cycle valid_out=0, last_out=0, busy_out=0, done_out=1 pulse, state IDLE via DONE. Abort coincident with final handshake is a normal completion. Ignored in IDLE/DONE.
- Undefined: port absent; scans always run to completion or reset.

## Structure
- Package scan_pkg: scan_state_t enum (IDLE, RUN, DONE), default HRES/VRES constants.
- Sub-module scan_axis: one axis counter with async reset, load value, limit, incr and wrap pulse; instantiated twice (column, row), column wrap drives row increment.

## Test plan
- HRES=320: start x0=10,y0=2,w=3,h=2, ready always high -> addrs 650,651,652,970,971,972; last on 972; done one cycle after.
- Same window, ready low every other cycle -> identical sequence, outputs stable while stalled, no beat duplicated or dropped.
- x0=318,w=5,y0=239,h=4 -> clipped to 2x1: addrs 76798,76799; last on 76799.
- w=0 (or x0=320) -> done_out pulse cycle after start, valid_out never high.
- rst_in asserted mid-scan (after 4 beats) -> outputs zero immediately, no done pulse; fresh start then runs full window.
- SCAN_ABORT_EN: abort_in at beat 3 of 6 -> valid_out low next cycle, done_out single pulse, last_out never high.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and default geometry for the framebuffer window scanner.
package scan_pkg;

  localparam int unsigned DEF_HRES = 320;
  localparam int unsigned DEF_VRES = 240;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/scan_axis.sv
// One loadable axis counter: counts from a loaded start value and wraps back to
// the base value when incremented at its limit.
module scan_axis #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic [WIDTH-1:0] i_base,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_incr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_at_lim_c
);

  assign o_at_lim_c = (o_count == i_limit);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count <= '0;
    end else if (i_load) begin
      o_count <= i_load_val;
    end else if (i_incr) begin
      o_count <= o_at_lim_c ? i_base : o_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/scan_window_ctrl.sv
// Clipped row-major window scanner with valid/ready beats and incremental addressing.
// Optional SCAN_ABORT_EN adds abort_in to terminate a running scan early.
module scan_window_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned HRES        = DEF_HRES,
  parameter int unsigned VRES        = DEF_VRES,
  parameter int unsigned COORD_WIDTH = 9,
  parameter int unsigned ADDR_WIDTH  = 17
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic [COORD_WIDTH-1:0] x0_in,
  input  logic [COORD_WIDTH-1:0] y0_in,
  input  logic [COORD_WIDTH-1:0] w_in,
  input  logic [COORD_WIDTH-1:0] h_in,
  input  logic                   ready_in,
`ifdef SCAN_ABORT_EN
  input  logic                   abort_in,
`endif
  output logic                   valid_out,
  output logic [ADDR_WIDTH-1:0]  addr_out,
  output logic [COORD_WIDTH-1:0] x_out,
  output logic [COORD_WIDTH-1:0] y_out,
  output logic                   last_out,
  output logic                   busy_out,
  output logic                   done_out
);

  localparam int unsigned CW1 = COORD_WIDTH + 1;

  scan_state_t r_state;
  scan_state_t w_state_nxt;

  logic [COORD_WIDTH-1:0] r_x0, r_y0, r_x_lim, r_y_lim;
  logic [ADDR_WIDTH-1:0]  r_row_base;

  logic [CW1-1:0]         w_x0_e, w_y0_e, w_w_e, w_h_e;
  logic [CW1-1:0]         w_x_room, w_y_room, w_w_eff, w_h_eff;
  logic                   w_empty;
  logic [COORD_WIDTH-1:0] w_x_lim_in, w_y_lim_in;
  logic [ADDR_WIDTH-1:0]  w_base_in;

  logic                   w_valid_nxt, w_busy_nxt, w_last_nxt, w_done_nxt;
  logic [ADDR_WIDTH-1:0]  w_addr_nxt, w_row_base_nxt;
  logic                   w_load, w_col_incr, w_row_incr;
  logic                   w_col_at_lim, w_row_at_lim;
  logic                   w_beat, w_final, w_abort;
  logic [COORD_WIDTH-1:0] w_x_inc, w_y_inc;

  // Clipping against the framebuffer edges; widened by one bit to avoid wrap.
  assign w_x0_e     = CW1'(x0_in);
  assign w_y0_e     = CW1'(y0_in);
  assign w_w_e      = CW1'(w_in);
  assign w_h_e      = CW1'(h_in);
  assign w_x_room   = CW1'(HRES) - w_x0_e;
  assign w_y_room   = CW1'(VRES) - w_y0_e;
  assign w_w_eff    = (w_w_e < w_x_room) ? w_w_e : w_x_room;
  assign w_h_eff    = (w_h_e < w_y_room) ? w_h_e : w_y_room;
  assign w_empty    = (w_x0_e >= CW1'(HRES)) || (w_y0_e >= CW1'(VRES)) ||
                      (w_in == '0) || (h_in == '0);
  assign w_x_lim_in = COORD_WIDTH'(w_x0_e + w_w_eff - CW1'(1));
  assign w_y_lim_in = COORD_WIDTH'(w_y0_e + w_h_eff - CW1'(1));
  assign w_base_in  = ADDR_WIDTH'(y0_in) * ADDR_WIDTH'(HRES);

  assign w_beat     = valid_out && ready_in;
  assign w_final    = w_col_at_lim && w_row_at_lim;
  assign w_x_inc    = x_out + COORD_WIDTH'(1);
  assign w_y_inc    = y_out + COORD_WIDTH'(1);
  assign w_row_incr = w_col_incr && w_col_at_lim;

`ifdef SCAN_ABORT_EN
  assign w_abort = abort_in;
`else
  assign w_abort = 1'b0;
`endif

  scan_axis #(.WIDTH(COORD_WIDTH)) u_col (
    .i_clk      (clk_in),
    .i_rst      (rst_in),
    .i_load     (w_load),
    .i_load_val (x0_in),
    .i_base     (r_x0),
    .i_limit    (r_x_lim),
    .i_incr     (w_col_incr),
    .o_count    (x_out),
    .o_at_lim_c (w_col_at_lim)
  );

  scan_axis #(.WIDTH(COORD_WIDTH)) u_row (
    .i_clk      (clk_in),
    .i_rst      (rst_in),
    .i_load     (w_load),
    .i_load_val (y0_in),
    .i_base     (r_y0),
    .i_limit    (r_y_lim),
    .i_incr     (w_row_incr),
    .o_count    (y_out),
    .o_at_lim_c (w_row_at_lim)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_valid_nxt    = valid_out;
    w_busy_nxt     = busy_out;
    w_last_nxt     = last_out;
    w_done_nxt     = 1'b0;
    w_addr_nxt     = addr_out;
    w_row_base_nxt = r_row_base;
    w_load         = 1'b0;
    w_col_incr     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_in) begin
          w_load = 1'b1;
          if (w_empty) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt    = RUN;
            w_valid_nxt    = 1'b1;
            w_busy_nxt     = 1'b1;
            w_row_base_nxt = w_base_in;
            w_addr_nxt     = w_base_in + ADDR_WIDTH'(x0_in);
            w_last_nxt     = (w_w_eff == CW1'(1)) && (w_h_eff == CW1'(1));
          end
        end
      end
      RUN: begin
        if ((w_beat && w_final) || w_abort) begin
          w_state_nxt = DONE;
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_last_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else if (w_beat) begin
          w_col_incr = 1'b1;
          if (w_col_at_lim) begin
            w_row_base_nxt = r_row_base + ADDR_WIDTH'(HRES);
            w_addr_nxt     = r_row_base + ADDR_WIDTH'(HRES) + ADDR_WIDTH'(r_x0);
            w_last_nxt     = (r_x0 == r_x_lim) && (w_y_inc == r_y_lim);
          end else begin
            w_addr_nxt = addr_out + ADDR_WIDTH'(1);
            w_last_nxt = (w_x_inc == r_x_lim) && w_row_at_lim;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= IDLE;
      r_x0       <= '0;
      r_y0       <= '0;
      r_x_lim    <= '0;
      r_y_lim    <= '0;
      r_row_base <= '0;
      valid_out  <= 1'b0;
      busy_out   <= 1'b0;
      last_out   <= 1'b0;
      done_out   <= 1'b0;
      addr_out   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_row_base <= w_row_base_nxt;
      valid_out  <= w_valid_nxt;
      busy_out   <= w_busy_nxt;
      last_out   <= w_last_nxt;
      done_out   <= w_done_nxt;
      addr_out   <= w_addr_nxt;
      if (w_load) begin
        r_x0    <= x0_in;
        r_y0    <= y0_in;
        r_x_lim <= w_x_lim_in;
        r_y_lim <= w_y_lim_in;
      end
    end
  end

endmodule

// File: tb/tb_scan_window_ctrl.sv
// Bench for scan_window_ctrl: directed vector table, corner sequences and random windows
// against a nested-loop reference of the clipped scan.
module tb_scan_window_ctrl;

  localparam int unsigned CW = 9;
  localparam int unsigned AW = 17;
  localparam int HRES_I = 320;
  localparam int VRES_I = 240;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic [CW-1:0] x0_in, y0_in, w_in, h_in;
  logic          ready_in;
`ifdef SCAN_ABORT_EN
  logic          abort_in;
`endif
  logic          valid_out;
  logic [AW-1:0] addr_out;
  logic [CW-1:0] x_out, y_out;
  logic          last_out, busy_out, done_out;

  int n_chk = 0;
  int n_err = 0;

  typedef struct { int addr; int x; int y; int last; } beat_t;
  beat_t q[$];

  typedef struct { int x0; int y0; int w; int h; int mode; int exp_n; int exp_first; int exp_last; } vec_t;
  vec_t vecs[9];

  scan_window_ctrl #(
    .HRES(320), .VRES(240), .COORD_WIDTH(CW), .ADDR_WIDTH(AW)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start_in  (start_in),
    .x0_in     (x0_in),
    .y0_in     (y0_in),
    .w_in      (w_in),
    .h_in      (h_in),
    .ready_in  (ready_in),
`ifdef SCAN_ABORT_EN
    .abort_in  (abort_in),
`endif
    .valid_out (valid_out),
    .addr_out  (addr_out),
    .x_out     (x_out),
    .y_out     (y_out),
    .last_out  (last_out),
    .busy_out  (busy_out),
    .done_out  (done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: every pixel of the clipped window in row-major order.
  task automatic build_model(input int x0, input int y0, input int w, input int h);
    int we, he;
    q.delete();
    we = (x0 >= HRES_I || w == 0) ? 0 : ((w < HRES_I - x0) ? w : HRES_I - x0);
    he = (y0 >= VRES_I || h == 0) ? 0 : ((h < VRES_I - y0) ? h : VRES_I - y0);
    for (int yy = y0; yy < y0 + he; yy++)
      for (int xx = x0; xx < x0 + we; xx++)
        q.push_back('{yy * HRES_I + xx, xx, yy,
                      (yy == y0 + he - 1 && xx == x0 + we - 1) ? 1 : 0});
  endtask

  task automatic issue_start(input int x0, input int y0, input int w, input int h);
    @(negedge clk_in);
    x0_in = CW'(x0); y0_in = CW'(y0); w_in = CW'(w); h_in = CW'(h);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  // mode 0: ready always high, 1: ready low every other cycle, 2: random ready.
  task automatic run_scan(input int x0, input int y0, input int w, input int h, input int mode,
                          output int nb, output int fa, output int la);
    int idx, cyc, bound;
    bit rdy;
    build_model(x0, y0, w, h);
    nb = 0; fa = -1; la = -1;
    issue_start(x0, y0, w, h);
    if (q.size() == 0) begin
      chk("empty_done", int'(done_out), 1);
      chk("empty_valid", int'(valid_out), 0);
      chk("empty_busy", int'(busy_out), 0);
      @(negedge clk_in);
      chk("empty_done_clear", int'(done_out), 0);
      chk("empty_valid2", int'(valid_out), 0);
      return;
    end
    idx = 0; cyc = 0; bound = 200 + 10 * q.size();
    while (idx < q.size() && cyc < bound) begin
      chk("valid", int'(valid_out), 1);
      chk("busy", int'(busy_out), 1);
      chk("done_in_run", int'(done_out), 0);
      chk("addr", int'(addr_out), q[idx].addr);
      chk("x", int'(x_out), q[idx].x);
      chk("y", int'(y_out), q[idx].y);
      chk("last", int'(last_out), q[idx].last);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = cyc[0];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ready_in = rdy;
      if (rdy && valid_out) begin
        if (nb == 0) fa = int'(addr_out);
        la = int'(addr_out);
        nb++;
      end
      @(negedge clk_in);
      cyc++;
      if (rdy) idx++;
    end
    ready_in = 1'b0;
    if (idx < q.size()) chk("scan_timeout", idx, q.size());
    chk("end_valid", int'(valid_out), 0);
    chk("end_busy", int'(busy_out), 0);
    chk("end_last", int'(last_out), 0);
    chk("end_done", int'(done_out), 1);
    @(negedge clk_in);
    chk("done_single", int'(done_out), 0);
  endtask

  initial begin
    int nb, fa, la;
    vecs[0] = '{10, 2, 3, 2, 0, 6, 650, 972};
    vecs[1] = '{10, 2, 3, 2, 1, 6, 650, 972};
    vecs[2] = '{318, 239, 5, 4, 0, 2, 76798, 76799};
    vecs[3] = '{0, 0, 0, 5, 0, 0, -1, -1};
    vecs[4] = '{320, 0, 4, 4, 0, 0, -1, -1};
    vecs[5] = '{0, 0, 1, 1, 1, 1, 0, 0};
    vecs[6] = '{319, 0, 1, 3, 0, 3, 319, 959};
    vecs[7] = '{0, 238, 2, 5, 2, 4, 76160, 76481};
    vecs[8] = '{5, 240, 1, 1, 0, 0, -1, -1};

    rst_in = 1'b1; start_in = 1'b0; ready_in = 1'b0;
    x0_in = '0; y0_in = '0; w_in = '0; h_in = '0;
`ifdef SCAN_ABORT_EN
    abort_in = 1'b0;
`endif
    repeat (3) @(negedge clk_in);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_done", int'(done_out), 0);
    chk("rst_last", int'(last_out), 0);
    chk("rst_addr", int'(addr_out), 0);
    chk("rst_xy", int'(x_out) + int'(y_out), 0);
    rst_in = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_scan(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].mode, nb, fa, la);
      chk("vec_nbeats", nb, vecs[i].exp_n);
      chk("vec_first_addr", fa, vecs[i].exp_first);
      chk("vec_last_addr", la, vecs[i].exp_last);
    end

    // Reset after four accepted beats, then a fresh full scan.
    issue_start(10, 2, 3, 2);
    ready_in = 1'b1;
    repeat (4) @(negedge clk_in);
    chk("pre_rst_addr", int'(addr_out), 971);
    rst_in = 1'b1;
    #1;
    chk("midrst_valid", int'(valid_out), 0);
    chk("midrst_busy", int'(busy_out), 0);
    chk("midrst_addr", int'(addr_out), 0);
    chk("midrst_xy", int'(x_out) + int'(y_out), 0);
    chk("midrst_last", int'(last_out), 0);
    ready_in = 1'b0;
    @(negedge clk_in);
    chk("midrst_no_done", int'(done_out), 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("post_rst_no_done", int'(done_out), 0);
    run_scan(10, 2, 3, 2, 0, nb, fa, la);
    chk("post_rst_nbeats", nb, 6);

`ifdef SCAN_ABORT_EN
    begin
      int last_seen;
      last_seen = 0;
      issue_start(10, 2, 3, 2);
      ready_in = 1'b1;
      repeat (2) begin
        last_seen |= int'(last_out);
        @(negedge clk_in);
      end
      chk("abort_beat3_addr", int'(addr_out), 652);
      last_seen |= int'(last_out);
      abort_in = 1'b1;
      @(negedge clk_in);
      abort_in = 1'b0;
      ready_in = 1'b0;
      chk("abort_valid", int'(valid_out), 0);
      chk("abort_busy", int'(busy_out), 0);
      chk("abort_done", int'(done_out), 1);
      last_seen |= int'(last_out);
      @(negedge clk_in);
      chk("abort_done_single", int'(done_out), 0);
      chk("abort_last_never", last_seen, 0);
    end
`endif

    for (int i = 0; i < 25; i++) begin
      int x0, y0, w, h;
      x0 = int'($urandom_range(0, 330));
      y0 = int'($urandom_range(0, 245));
      w  = int'($urandom_range(0, 8));
      h  = int'($urandom_range(0, 5));
      run_scan(x0, y0, w, h, 2, nb, fa, la);
      chk("rnd_nbeats", nb, q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
